// File: rtl/cache_arbiter.sv
// Arbiter sharing one physical-memory line port between icache and dcache.
// Round-robin on ties; the winner's command is latched and held until pmem_resp.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_grant;
  logic                r_cmd_read;
  logic                r_cmd_write;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [LINE_W-1:0]   r_wdata_q;
  logic                w_i_req;
  logic                w_d_req;

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;

  // Command and payload are captured only on the IDLE -> SERVE transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_cmd_read   <= 1'b0;
      r_cmd_write  <= 1'b0;
      r_addr_q     <= '0;
      r_wdata_q    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == SERVE_I) begin
        r_cmd_read   <= 1'b1;
        r_cmd_write  <= 1'b0;
        r_addr_q     <= i_pmem_address;
        r_last_grant <= 1'b0;
      end else if (r_state == IDLE && w_next == SERVE_D) begin
        r_cmd_read   <= d_pmem_read & ~d_pmem_write;
        r_cmd_write  <= d_pmem_write;
        r_addr_q     <= d_pmem_address;
        r_wdata_q    <= d_pmem_wdata;
        r_last_grant <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) w_next = r_last_grant ? SERVE_I : SERVE_D;
        else if (w_i_req)       w_next = SERVE_I;
        else if (w_d_req)       w_next = SERVE_D;
        else                    w_next = IDLE;
      end
      SERVE_I: if (pmem_resp) w_next = IDLE;
      SERVE_D: if (pmem_resp) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Responses are combinational so completion adds no latency.
  always_comb begin
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    if (r_state != IDLE) begin
      pmem_read  = r_cmd_read;
      pmem_write = r_cmd_write;
    end
    if (r_state == SERVE_I) i_pmem_resp = pmem_resp;
    if (r_state == SERVE_D) d_pmem_resp = pmem_resp;
  end

  assign pmem_address = r_addr_q;
  assign pmem_wdata   = r_wdata_q;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and checks them whenever a requester resp fires.
module tb_cache_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int n_chk  = 0;
  int n_pass = 0;
  logic [LINE_W:0] exp_q[$];   // {src (0=I,1=D), rdata}

  localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_12 = {16{16'h1234}};
  localparam logic [LINE_W-1:0] PAT_D  = {8{32'hDEAD_BEEF}};
  localparam logic [LINE_W-1:0] PAT_I  = {8{32'h0BAD_F00D}};

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: every requester resp must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (i_pmem_resp || d_pmem_resp)) begin
      if (i_pmem_resp && d_pmem_resp) begin
        chk("both_resp", 2, 1);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_resp", {254'd0, d_pmem_resp, i_pmem_resp}, 0);
      end else begin
        logic [LINE_W:0] e;
        e = exp_q.pop_front();
        chk("resp_src", d_pmem_resp, e[LINE_W]);
        chk("resp_rdata", d_pmem_resp ? d_pmem_rdata : i_pmem_rdata, e[LINE_W-1:0]);
      end
    end
  end

  // Acts as memory: waits for a command, checks it, answers after lat cycles.
  task automatic serve(input string tag, input bit exp_rd, input bit exp_wr,
                       input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                       input int lat, input logic [LINE_W-1:0] rdata, input int exp_wait);
    int waits = 0;
    while (!(pmem_read || pmem_write) && waits < 20) begin
      tick();
      waits++;
    end
    chk({tag, "_grant_wait"}, waits, exp_wait);
    if (waits >= 20) return;
    chk({tag, "_rd"}, pmem_read, exp_rd);
    chk({tag, "_wr"}, pmem_write, exp_wr);
    chk({tag, "_addr"}, pmem_address, addr);
    if (exp_wr) chk({tag, "_wdata"}, pmem_wdata, wdata);
    for (int k = 0; k < lat; k++) tick();
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    #1;
    chk({tag, "_hold_cmd"}, {pmem_read, pmem_write}, {exp_rd, exp_wr});
    chk({tag, "_hold_addr"}, pmem_address, addr);
    if (exp_wr) chk({tag, "_hold_wdata"}, pmem_wdata, wdata);
    tick();
    pmem_resp = 1'b0;
    chk({tag, "_idle_after"}, {pmem_read, pmem_write}, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    #12;
    chk("rst_cmd", {pmem_read, pmem_write}, 2'b00);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    tick();
    rst = 1'b0;
    tick();

    // icache alone
    i_pmem_read = 1; i_pmem_address = 32'h40;
    exp_q.push_back({1'b0, PAT_A5});
    serve("i_alone", 1, 0, 32'h40, '0, 3, PAT_A5, 1);
    i_pmem_read = 0;
    tick();

    // dcache write-back; requester input changes after grant
    d_pmem_write = 1; d_pmem_address = 32'h1000; d_pmem_wdata = PAT_12;
    tick();
    d_pmem_wdata = '0; d_pmem_write = 0; d_pmem_address = 32'hFFFF_0000;
    exp_q.push_back({1'b1, PAT_D});
    serve("d_wb", 0, 1, 32'h1000, PAT_12, 2, PAT_D, 0);
    tick();

    // tie from reset: I first, one idle cycle, then D
    rst = 1; tick(); rst = 0; tick();
    i_pmem_read = 1; i_pmem_address = 32'h80;
    d_pmem_read = 1; d_pmem_address = 32'h100;
    exp_q.push_back({1'b0, PAT_I});
    serve("tie_i", 1, 0, 32'h80, '0, 1, PAT_I, 1);
    i_pmem_read = 0;
    exp_q.push_back({1'b1, PAT_D});
    serve("tie_d", 1, 0, 32'h100, '0, 1, PAT_D, 1);

    // continuous requests alternate I, D, I, D, I, D
    i_pmem_read = 1;
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) begin
        exp_q.push_back({1'b0, PAT_I ^ LINE_W'(n)});
        serve("rr_i", 1, 0, 32'h80, '0, 1, PAT_I ^ LINE_W'(n), 1);
      end else begin
        exp_q.push_back({1'b1, PAT_D ^ LINE_W'(n)});
        serve("rr_d", 1, 0, 32'h100, '0, 1, PAT_D ^ LINE_W'(n), 1);
      end
    end
    i_pmem_read = 0; d_pmem_read = 0;
    tick();

    // async reset mid write-back
    d_pmem_write = 1; d_pmem_address = 32'h300; d_pmem_wdata = PAT_A5;
    tick();
    chk("pre_rst_wr", pmem_write, 1);
    rst = 1; pmem_resp = 1;
    #1;
    chk("mid_rst_wr", pmem_write, 0);
    chk("mid_rst_addr", pmem_address, 0);
    chk("mid_rst_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    tick();
    rst = 0; pmem_resp = 0; d_pmem_write = 0;
    tick();
    i_pmem_read = 1; i_pmem_address = 32'h80;
    d_pmem_read = 1; d_pmem_address = 32'h100;
    exp_q.push_back({1'b0, PAT_A5});
    serve("post_rst_tie", 1, 0, 32'h80, '0, 1, PAT_A5, 1);
    i_pmem_read = 0; d_pmem_read = 0;
    tick();

    // pmem_resp in IDLE with no requests is ignored
    pmem_resp = 1; pmem_rdata = PAT_12;
    tick();
    pmem_resp = 0;
    chk("idle_resp_cmd", {pmem_read, pmem_write}, 2'b00);
    tick();

    // D read+write together (with a stray pmem_resp): write only
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h200; d_pmem_wdata = PAT_D;
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    d_pmem_read = 0; d_pmem_write = 0;
    exp_q.push_back({1'b1, PAT_I});
    serve("d_rw", 0, 1, 32'h200, PAT_D, 1, PAT_I, 0);

    tick(); tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end
endmodule
